// File: rtl/sisc_pkg.sv
// Shared definitions for the SISC fetch datapath: opcode values, fetch
// state encoding, the NOOP instruction word and instruction-register field
// accessors.
package sisc_pkg;

    // Instruction opcodes carried in ir[31:28]
    typedef enum logic [3:0] {
        OP_NOOP = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_NOT  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_XOR  = 4'h6,
        OP_RROT = 4'h7,
        OP_BRR  = 4'h8,
        OP_BRA  = 4'h9,
        OP_HLT  = 4'hF
    } opcode_e;

    // Instruction-memory read handshake states
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_REQ  = 2'd1,
        FS_DONE = 2'd2
    } fetch_state_e;

    localparam logic [31:0] NOOP_INSTR = 32'h0000_0000;

    function automatic logic [3:0] ir_opcode(input logic [31:0] ir);
        return ir[31:28];
    endfunction

    function automatic logic [3:0] ir_mm(input logic [31:0] ir);
        return ir[27:24];
    endfunction

    function automatic logic [15:0] ir_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

endpackage

// File: rtl/sisc_pc_reg.sv
// Program counter with its next-PC selection: sequential increment or a
// branch target that is either absolute (imm) or PC-relative (PC + sext(imm)).
// All arithmetic wraps modulo 2^AW.
module sisc_pc_reg #(
    parameter int AW = 16
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          pc_rst_i,
    input  logic          pc_sel_i,
    input  logic          pc_write_i,
    input  logic          br_sel_i,
    input  logic [15:0]   imm_i,
    output logic [AW-1:0] pc_o
);

    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] imm_abs, imm_sext;
    logic [AW-1:0] br_target, next_pc;

    // Fit the 16-bit immediate to the PC width: zero-extend for absolute
    // targets, sign-extend for relative offsets.
    if (AW > 16) begin : g_wide
        assign imm_abs  = {{(AW-16){1'b0}}, imm_i};
        assign imm_sext = {{(AW-16){imm_i[15]}}, imm_i};
    end else begin : g_narrow
        assign imm_abs  = imm_i[AW-1:0];
        assign imm_sext = imm_i[AW-1:0];
    end

    // Next-PC select; a clear takes priority over a load
    always_comb begin
        br_target = br_sel_i ? imm_abs : (pc_q + imm_sext);
        next_pc   = pc_sel_i ? br_target : (pc_q + AW'(1));
        pc_d      = pc_q;
        if (pc_rst_i) begin
            pc_d = '0;
        end else if (pc_write_i) begin
            pc_d = next_pc;
        end
    end

    // PC register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC fetch stage: PC (via sisc_pc_reg), instruction-memory read handshake
// and instruction register. fetch_stall holds the control FSM while a read
// is outstanding.
// Optional feature macro SISC_FETCH_TIMEOUT_EN: abandon a read after
// TIMEOUT_CYC cycles without imem_ack, load NOOP and raise sticky fetch_err.
module sisc_fetch_unit
    import sisc_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          pc_rst,
    input  logic          pc_sel,
    input  logic          pc_write,
    input  logic          br_sel,
    input  logic          ir_load,
    output logic [AW-1:0] imem_addr,
    output logic          imem_req,
    input  logic          imem_ack,
    input  logic [DW-1:0] imem_rdata,
    output logic [DW-1:0] ir_out,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [15:0]   imm,
    output logic [AW-1:0] pc_out,
    output logic          fetch_stall,
    output logic          fetch_err
);

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] ir_q, ir_d;

`ifdef SISC_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
`else
    // The timeout length only matters when the timeout is built in
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
`endif

    sisc_pc_reg #(
        .AW(AW)
    ) u_pc_reg (
        .clk        (clk),
        .rst_f      (rst_f),
        .pc_rst_i   (pc_rst),
        .pc_sel_i   (pc_sel),
        .pc_write_i (pc_write),
        .br_sel_i   (br_sel),
        .imm_i      (imm),
        .pc_o       (pc_out)
    );

    // Fetch FSM next-state: address captured at launch, IR written on ack
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ir_d    = ir_q;
`ifdef SISC_FETCH_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            FS_IDLE: begin
                if (ir_load) begin
                    state_d = FS_REQ;
                    addr_d  = pc_out;
`ifdef SISC_FETCH_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            FS_REQ: begin
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = FS_DONE;
                end
`ifdef SISC_FETCH_TIMEOUT_EN
                // An ack arriving on the final allowed cycle still wins
                else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                    ir_d    = DW'(NOOP_INSTR);
                    err_d   = 1'b1;
                    state_d = FS_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
`endif
            end
            FS_DONE: begin
                state_d = FS_IDLE;
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase
    end

    // Fetch state, address and instruction registers
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= FS_IDLE;
            addr_q  <= '0;
            ir_q    <= DW'(NOOP_INSTR);
`ifdef SISC_FETCH_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ir_q    <= ir_d;
`ifdef SISC_FETCH_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    // Request and stall come straight from state so reset drops them at once
    assign imem_req    = (state_q == FS_REQ);
    assign fetch_stall = (state_q == FS_REQ);
    assign imem_addr   = addr_q;
    assign ir_out      = ir_q;
    assign opcode      = ir_opcode(ir_q[31:0]);
    assign mm          = ir_mm(ir_q[31:0]);
    assign imm         = ir_imm(ir_q[31:0]);

`ifdef SISC_FETCH_TIMEOUT_EN
    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule
